struct_uflop_sched: RTL and testbench
=====================================

Name: struct_uflop_sched

Overview:
- Round-robin scheduler that shares one loadable, wrapping up-counter between NREQ requesters.
- Each requester asks for one operation per request: load a value, or increment.
- The block arbitrates, drives the counter's load/enable/data, and returns a grant plus the updated count.
- Supports a bounded "lock" burst, so one requester can issue back-to-back operations without interleaving.

Parameters:
- NREQ, 4, number of requesters (1..8).
- WIDTH, 3, counter width in bits.
- MAX_LOCK, 8, maximum consecutive grants one owner can hold in LOCKED (>=1).

Ports:
- clk2  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request; held until the matching gnt is seen.
- op_load  in  NREQ  per-requester op: 1 = load, 0 = increment.
- load_val  in  NREQ*WIDTH  per-requester load data; slice i is bits [i*WIDTH +: WIDTH].
- lock  in  NREQ  per-requester request for burst ownership.
- gnt  out  NREQ  one-hot registered grant; the op is applied in this cycle.
- out  out  WIDTH  registered counter value.
- out_valid  out  1  one-cycle pulse: out holds the result of the op granted in the previous cycle.
- busy  out  1  high while the FSM is in LOCKED.

Behaviour:
- Reset (async, active-high): gnt=0, out=0, out_valid=0, busy=0, rr_ptr=0, FSM=IDLE, lock_cnt=0. Any in-flight op is dropped.
- Eligible set, IDLE: req masked by the current gnt. A requester granted this cycle cannot win again in the same cycle.
- Arbitration, IDLE: winner w is the first eligible index at or after rr_ptr, wrapping modulo NREQ.
  - Registered at the edge: gnt<=onehot(w); op_load[w] and load_val[w] are latched; rr_ptr<=(w+1)%NREQ.
  - If lock[w]=1: FSM<=LOCKED, owner<=w, lock_cnt<=1.
- Latency: req sampled in cycle t -> gnt in t+1 -> counter updates at the end of t+1 -> out and out_valid in t+2.
- Throughput: one op per cycle. Distinct requesters can be granted back-to-back. One unlocked requester is granted at most every other cycle.
- Counter update in a gnt cycle:
  - Latched op load: count<=latched val.
  - Otherwise: count<=(count+1) mod 2^WIDTH; 7 wraps to 0 at WIDTH=3.
  - No gnt: count holds.
- LOCKED:
  - Each cycle with req[owner]&&lock[owner]&&lock_cnt<MAX_LOCK: gnt<=onehot(owner), owner unmasked, lock_cnt++.
  - Exit when req[owner]=0, lock[owner]=0, or lock_cnt==MAX_LOCK. In the exit cycle: FSM<=IDLE and normal arbitration runs with owner masked. rr_ptr is already past owner.
  - A forced release at MAX_LOCK requires the owner to drop lock, or to re-win round-robin, before a new burst.
- busy: registered (FSM==LOCKED).
- NREQ=1: arbiter degenerates to a pass-through. The mask still forces every-other-cycle unless locked.
- Unknown or unused bits in load_val are ignored when op_load=0.

Decomposition:
- Package struct_uflop_sched_pkg:
  - FSM enum {IDLE, LOCKED}.
  - onehot and round-robin-pick functions parameterised by NREQ.
  - Localparam for the pointer width, $clog2(NREQ) min 1.
- Sub-module struct_uflop_core (WIDTH; clk2, reset, load, enable, a, out): the loadable wrapping counter. The scheduler instantiates it once, drives load/enable from the gnt cycle, and registers out.

Test Plan:
1. Reset: assert reset mid-cycle with no clock -> gnt=0, out=0, out_valid=0, busy=0 immediately.
2. Wrap: req[0]=1, op_load=0, held and re-asserted for 9 grants (WIDTH=3) -> gnt[0] every other cycle; out sequence 1,2,...,7,0,1, each with out_valid.
3. Fairness: rr_ptr=0, req=4'b1111, all increment, held until granted -> gnt order 0,1,2,3 on consecutive cycles; out 1,2,3,4.
4. Collision: rr_ptr=3, count=2, req[0] load 5 and req[3] increment in the same cycle -> gnt[3] then gnt[0]; out=3 then out=5.
5. Lock bound: req[1] with lock=1 and 10 increments, req[2] pending from cycle 1 -> gnt[1] for 8 consecutive cycles, busy high; then gnt[2]; out advances by exactly 8 before req[2]'s op.
6. Reset in burst: assert reset at the 3rd LOCKED grant -> busy=0, gnt=0, out=0 immediately; after release, req[2] is granted first, since rr_ptr=0 and only req[2] is asserted.

Source files
------------

// File: rtl/struct_uflop_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
// Helpers work on MAX_NREQ-wide vectors so any NREQ up to 8 can use them.
package struct_uflop_sched_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam int unsigned MAX_NREQ  = 8;
    localparam int unsigned PTR_W_MAX = $clog2(MAX_NREQ);
    localparam int unsigned NW        = PTR_W_MAX + 1;

    typedef struct packed {
        logic                 found;
        logic [PTR_W_MAX-1:0] idx;
    } pick_t;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_NREQ-1:0] onehot(
        input logic [PTR_W_MAX-1:0] idx
    );
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set bit of elig at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_NREQ-1:0]  elig,
        input logic [PTR_W_MAX-1:0] ptr,
        input logic [NW-1:0]        n
    );
        pick_t         p;
        logic [NW-1:0] j;
        p = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            j = {1'b0, ptr} + NW'(k);
            if (j >= n) begin
                j = j - n;
            end
            if ((NW'(k) < n) && !p.found && elig[j[PTR_W_MAX-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[PTR_W_MAX-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/struct_uflop_sched_if.sv
// Requester-side bundle of the counter scheduler.
// master = requesters, slave = scheduler.
interface struct_uflop_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       op_load;
    logic [NREQ*WIDTH-1:0] load_val;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output req, op_load, load_val, lock,
        input  gnt, out, out_valid, busy
    );

    modport slave (
        input  req, op_load, load_val, lock,
        output gnt, out, out_valid, busy
    );
endinterface

// File: rtl/struct_uflop_core.sv
// Loadable wrapping up-counter shared by all requesters.
// Load takes priority over enable.
module struct_uflop_core #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk2,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= a;
        end else if (enable) begin
            out <= out + 1'b1;
        end
    end

endmodule

// File: rtl/struct_uflop_sched.sv
// Round-robin scheduler for one shared counter, with bounded lock bursts.
// Grant and latched op are registered; the counter applies the op in the gnt cycle.
module struct_uflop_sched #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MAX_LOCK = 8
) (
    input logic                 clk2,
    input logic                 reset,
    struct_uflop_sched_if.slave bus
);
    import struct_uflop_sched_pkg::*;

    localparam int unsigned   PW   = ptr_width(NREQ);
    localparam int unsigned   LW   = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK);
    localparam logic [NW-1:0] NR   = NW'(NREQ);

    state_t              state;
    state_t              state_n;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       ptr_n;
    logic [PW-1:0]       owner;
    logic [PW-1:0]       owner_n;
    logic [PW-1:0]       win;
    logic [LW-1:0]       lock_cnt;
    logic [LW-1:0]       cnt_n;
    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     gnt_n;
    logic [NREQ-1:0]     mask;
    logic [NREQ-1:0]     own_oh;
    logic [NREQ-1:0]     win_oh;
    logic [MAX_NREQ-1:0] elig;
    logic [MAX_NREQ-1:0] own_full;
    logic [MAX_NREQ-1:0] win_full;
    logic [NW-1:0]       inc;
    logic [NW-1:0]       nxt;
    logic                lat_load;
    logic                load_n;
    logic [WIDTH-1:0]    lat_val;
    logic [WIDTH-1:0]    val_n;
    logic                out_valid_r;
    logic                stay;
    logic                arb;
    logic                core_load;
    logic                core_en;
    logic                unused;
    pick_t               pick;

    assign own_full = onehot(PTR_W_MAX'(owner));
    assign own_oh   = own_full[NREQ-1:0];

    // The owner is masked whenever arbitration runs out of LOCKED.
    assign mask = gnt_r | ((state == LOCKED) ? own_oh : '0);
    assign elig = MAX_NREQ'(bus.req & ~mask);
    assign pick = rr_pick(elig, PTR_W_MAX'(rr_ptr), NR);

    assign win      = pick.idx[PW-1:0];
    assign win_full = onehot(pick.idx);
    assign win_oh   = win_full[NREQ-1:0];
    assign inc      = {1'b0, pick.idx} + NW'(1);
    assign nxt      = (inc >= NR) ? '0 : inc;

    assign stay = bus.req[owner] && bus.lock[owner] && (lock_cnt < LMAX);

    assign unused = ^{own_full, win_full, nxt, pick.idx};

    always_comb begin
        state_n = state;
        owner_n = owner;
        cnt_n   = lock_cnt;
        ptr_n   = rr_ptr;
        gnt_n   = '0;
        load_n  = lat_load;
        val_n   = lat_val;
        arb     = 1'b0;
        unique case (state)
            IDLE: begin
                arb = 1'b1;
            end
            LOCKED: begin
                if (stay) begin
                    gnt_n  = own_oh;
                    load_n = bus.op_load[owner];
                    val_n  = bus.load_val[owner*WIDTH +: WIDTH];
                    cnt_n  = lock_cnt + 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    arb     = 1'b1;
                end
            end
        endcase
        if (arb && pick.found) begin
            gnt_n  = win_oh;
            load_n = bus.op_load[win];
            val_n  = bus.load_val[win*WIDTH +: WIDTH];
            ptr_n  = nxt[PW-1:0];
            if (bus.lock[win]) begin
                state_n = LOCKED;
                owner_n = win;
                cnt_n   = LW'(1);
            end
        end
    end

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            lock_cnt    <= '0;
            rr_ptr      <= '0;
            gnt_r       <= '0;
            lat_load    <= 1'b0;
            lat_val     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            lock_cnt    <= cnt_n;
            rr_ptr      <= ptr_n;
            gnt_r       <= gnt_n;
            lat_load    <= load_n;
            lat_val     <= val_n;
            out_valid_r <= |gnt_r;
        end
    end

    assign core_load = (|gnt_r) & lat_load;
    assign core_en   = (|gnt_r) & ~lat_load;

    struct_uflop_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk2  (clk2),
        .reset (reset),
        .load  (core_load),
        .enable(core_en),
        .a     (lat_val),
        .out   (bus.out)
    );

    assign bus.gnt       = gnt_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = (state == LOCKED);

endmodule

// File: tb/tb_struct_uflop_sched.sv
// Scoreboard bench for struct_uflop_sched.
// Grant order/timing is pushed up front; counter results are queued per grant.
module tb_struct_uflop_sched;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 3;
    localparam int MAX_LOCK = 8;

    logic clk2 = 1'b0;
    logic reset;

    always #5 clk2 = ~clk2;

    struct_uflop_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    struct_uflop_sched #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk2 (clk2),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [NREQ-1:0] g;
        int              cyc;
        logic            busy;
    } gexp_t;

    int               tests = 0;
    int               fails = 0;
    int               cyc;
    gexp_t            gq[$];
    logic [WIDTH-1:0] oq[$];
    int               n_ops[NREQ];
    logic             is_ld[NREQ];
    logic [WIDTH-1:0] ld_val[NREQ];
    logic             lk[NREQ];
    logic [WIDTH-1:0] model;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]     = (n_ops[i] > 0);
            bus.op_load[i] = is_ld[i];
            bus.load_val[i*WIDTH +: WIDTH] =
                is_ld[i] ? ld_val[i] : WIDTH'($urandom);
            bus.lock[i]    = lk[i] && (n_ops[i] > 0);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            n_ops[i]  = 0;
            is_ld[i]  = 1'b0;
            ld_val[i] = '0;
            lk[i]     = 1'b0;
        end
        drive();
    endtask

    task automatic setreq(input int i, input int n, input logic ld,
                          input logic [WIDTH-1:0] v, input logic l);
        n_ops[i]  = n;
        is_ld[i]  = ld;
        ld_val[i] = v;
        lk[i]     = l;
    endtask

    task automatic expect_g(input int i, input int c, input logic b);
        logic [NREQ-1:0] g;
        g    = '0;
        g[i] = 1'b1;
        gq.push_back('{g: g, cyc: c, busy: b});
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NREQ; i++) begin
            if (n_ops[i] > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        gq.delete();
        oq.delete();
        @(negedge clk2);
        reset = 1'b0;
        @(posedge clk2);
        #1;
        model = '0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_out"}, bus.out, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    // Runs until every queued op is granted and its result seen.
    task automatic run(input int budget, input int abort_at);
        gexp_t e;
        int    idx;
        cyc = 0;
        drive();
        forever begin
            if (gq.size() == 0 && oq.size() == 0 && all_idle()) break;
            if (cyc >= budget) begin
                chk("timeout", 1, 0);
                break;
            end
            @(posedge clk2);
            #1;
            cyc++;
            if (bus.out_valid) begin
                if (oq.size() == 0) chk("spurious_valid", 1, 0);
                else chk("out", bus.out, oq.pop_front());
            end
            if (bus.gnt != 0) begin
                if (gq.size() == 0) begin
                    chk("extra_gnt", bus.gnt, 0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt", bus.gnt, e.g);
                    chk("gnt_cyc", cyc, e.cyc);
                    chk("busy", bus.busy, e.busy);
                end
                idx = -1;
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (bus.gnt[k]) idx = k;
                end
                if (idx >= 0) begin
                    if (is_ld[idx]) model = ld_val[idx];
                    else model = model + 1'b1;
                    oq.push_back(model);
                    if (n_ops[idx] > 0) n_ops[idx]--;
                end
            end
            if (abort_at == cyc) break;
            drive();
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc   = 0;
        model = '0;
        clear_reqs();
        #3;
        check_reset_outs("por");
        @(negedge clk2);
        reset = 1'b0;
        @(posedge clk2);
        #1;

        // Single increment requester: every other cycle, wraps 7 -> 0.
        setreq(0, 9, 1'b0, '0, 1'b0);
        for (int k = 0; k < 9; k++) expect_g(0, 1 + 2 * k, 1'b0);
        run(40, 0);
        chk("wrap_final", bus.out, 1);

        // Asynchronous reset mid-cycle, no clock edge.
        reset = 1'b1;
        #2;
        check_reset_outs("async");

        // Fairness from rr_ptr = 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) setreq(i, 1, 1'b0, '0, 1'b0);
        for (int i = 0; i < NREQ; i++) expect_g(i, 1 + i, 1'b0);
        run(20, 0);

        // Collision with rr_ptr = 3 and count = 2.
        do_reset();
        setreq(2, 1, 1'b1, 3'd2, 1'b0);
        expect_g(2, 1, 1'b0);
        run(10, 0);
        setreq(0, 1, 1'b1, 3'd5, 1'b0);
        setreq(3, 1, 1'b0, '0, 1'b0);
        expect_g(3, 1, 1'b0);
        expect_g(0, 2, 1'b0);
        run(10, 0);

        // Lock bound, then req[2], then requester 1 re-wins a new burst.
        do_reset();
        setreq(1, 10, 1'b0, '0, 1'b1);
        setreq(2, 1, 1'b1, 3'd5, 1'b0);
        for (int k = 1; k <= MAX_LOCK; k++) expect_g(1, k, 1'b1);
        expect_g(2, 9, 1'b0);
        expect_g(1, 10, 1'b1);
        expect_g(1, 11, 1'b1);
        run(40, 0);
        chk("lock_exit_busy", bus.busy, 0);

        // Reset at the third LOCKED grant.
        do_reset();
        setreq(1, 10, 1'b0, '0, 1'b1);
        for (int k = 1; k <= 3; k++) expect_g(1, k, 1'b1);
        run(20, 3);
        reset = 1'b1;
        #2;
        check_reset_outs("burst_rst");
        do_reset();
        setreq(2, 1, 1'b0, '0, 1'b0);
        expect_g(2, 1, 1'b0);
        run(10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
